// File: rtl/async_lib_pkg.sv
// ---------------------------------------------------------------------------
// async_lib_pkg
// Shared types and helpers for the locker sink.
//   sink_state_t    : FSM states of the sink (IDLE, ACK, RELEASE)
//   SINK_FIFO_DEPTH : depth of the sink output FIFO
//   idx_width()     : bits needed for a channel index (never less than 1)
// ---------------------------------------------------------------------------
package async_lib_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACK     = 2'd1,
    RELEASE = 2'd2
  } sink_state_t;

  localparam int SINK_FIFO_DEPTH = 2;

  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/sync_ff.sv
// ---------------------------------------------------------------------------
// sync_ff
// N-stage single-bit flip-flop synchroniser.
//   clk    : destination clock
//   rst    : asynchronous active-low reset, clears every stage
//   d      : asynchronous input
//   q      : synchronised output, stages clock edges after d
// ---------------------------------------------------------------------------
module sync_ff #(
  parameter int stages = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic [stages-1:0] stage;

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge value; blocking here would collapse the chain.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stage <= '0;
    end else begin
      stage <= {stage[stages-2:0], d};
    end
  end

  assign q = stage[stages-1];

endmodule

// File: rtl/locker_sync_sink.sv
// ---------------------------------------------------------------------------
// locker_sync_sink
// Clocked consumer behind the arbiter locker. Synchronises the per-channel
// 4-phase requests, captures the granted channel's bundled data into a
// 2-entry FIFO, returns a return-to-zero ack, and streams captured words
// out on valid/ready.
//
// Ports
//   clk       : system clock
//   rst       : asynchronous active-low reset
//   req_in    : per-channel 4-phase request (at most one high)
//   data_in   : bundled data, channel i at [i*width +: width]
//   ack_out   : per-channel registered acknowledge
//   err       : sticky protocol error (only with LOCKER_SYNC_SINK_ERR_EN)
//   valid_out : FIFO head holds a word
//   ready_in  : downstream accepts the head word
//   data_out  : FIFO head data
//   chan_out  : channel index of the FIFO head word
//
// Build option
//   LOCKER_SYNC_SINK_ERR_EN : adds the err output and its checking logic.
// ---------------------------------------------------------------------------
module locker_sync_sink
  import async_lib_pkg::*;
#(
  parameter int size        = 2,
  parameter int width       = 8,
  parameter int sync_stages = 2
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [size-1:0]                req_in,
  input  logic [size*width-1:0]          data_in,
  output logic [size-1:0]                ack_out,
`ifdef LOCKER_SYNC_SINK_ERR_EN
  output logic                           err,
`endif
  output logic                           valid_out,
  input  logic                           ready_in,
  output logic [width-1:0]               data_out,
  output logic [idx_width(size)-1:0]     chan_out
);

  localparam int CW = idx_width(size);

  typedef struct packed {
    logic [CW-1:0]    chan;
    logic [width-1:0] data;
  } entry_t;

  // -------------------------------------------------------------------------
  // Request synchronisers. data_in is deliberately not synchronised: it is
  // bundled with req and stable for as long as req is high.
  // -------------------------------------------------------------------------
  logic [size-1:0] req_s;

  for (genvar g = 0; g < size; g++) begin : g_sync
    sync_ff #(.stages(sync_stages)) u_sync (
      .clk (clk),
      .rst (rst),
      .d   (req_in[g]),
      .q   (req_s[g])
    );
  end

  // -------------------------------------------------------------------------
  // Lowest asserted synchronised request and its data slice.
  // -------------------------------------------------------------------------
  logic             any_req;
  logic [CW-1:0]    pick;
  logic [width-1:0] sel_data;

  // NOTE: every signal assigned in an always_comb gets a default first, so
  // no path through the block can leave it unassigned and infer a latch.
  always_comb begin
    any_req  = 1'b0;
    pick     = '0;
    sel_data = '0;
    // Descending scan: the last hit, the lowest index, wins.
    for (int i = size - 1; i >= 0; i--) begin
      if (req_s[i]) begin
        any_req  = 1'b1;
        pick     = CW'(i);
        sel_data = data_in[i*width +: width];
      end
    end
  end

  // -------------------------------------------------------------------------
  // Handshake FSM
  // -------------------------------------------------------------------------
  sink_state_t     state, state_d;
  logic [CW-1:0]   idx, idx_d;
  logic [size-1:0] ack_d;
  logic            push;
  logic            pop;
  logic            full;

  always_comb begin
    state_d = state;
    idx_d   = idx;
    ack_d   = ack_out;
    push    = 1'b0;
    unique case (state)
      IDLE: begin
        // A full FIFO withholds the ack, which stalls the locker upstream.
        if (any_req && !full) begin
          push        = 1'b1;
          idx_d       = pick;
          ack_d       = '0;
          ack_d[pick] = 1'b1;
          state_d     = ACK;
        end
      end
      ACK: begin
        if (!req_s[idx]) begin
          ack_d   = '0;
          state_d = RELEASE;
        end
      end
      // One dead cycle so a req_s still draining from the locker's lock
      // release is not mistaken for a fresh request.
      RELEASE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      idx     <= '0;
      ack_out <= '0;
    end else begin
      state   <= state_d;
      idx     <= idx_d;
      ack_out <= ack_d;
    end
  end

  // -------------------------------------------------------------------------
  // 2-entry output FIFO. Push is gated by full as seen before this edge's
  // pop, so a push never lands on a full FIFO even while it drains.
  // -------------------------------------------------------------------------
  entry_t     mem [SINK_FIFO_DEPTH];
  logic       wr_ptr;
  logic       rd_ptr;
  logic [1:0] count;

  assign full = (count == 2'(SINK_FIFO_DEPTH));
  assign pop  = valid_out && ready_in;

  // NOTE: the storage is reset (it is only two words) so the head outputs
  // read as zero out of reset instead of carrying X downstream.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < SINK_FIFO_DEPTH; i++) begin
        mem[i] <= '0;
      end
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= '{chan: pick, data: sel_data};
        wr_ptr      <= ~wr_ptr;
      end
      if (pop) begin
        rd_ptr <= ~rd_ptr;
      end
      unique case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

  assign valid_out = (count != 2'd0);
  assign data_out  = mem[rd_ptr].data;
  assign chan_out  = mem[rd_ptr].chan;

`ifdef LOCKER_SYNC_SINK_ERR_EN
  // -------------------------------------------------------------------------
  // Sticky protocol checker: several requests at once, or the served
  // channel's request dropping while the FSM is back in IDLE (a request
  // that rose after the handshake and was withdrawn without an ack).
  // -------------------------------------------------------------------------
  logic [size-1:0] req_s_d;
  logic            served;
  logic            multi_req;
  logic            idle_fall;

  assign multi_req = ($countones(req_s) > 1);
  assign idle_fall = (state == IDLE) && served && req_s_d[idx] && !req_s[idx];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      err     <= 1'b0;
      req_s_d <= '0;
      served  <= 1'b0;
    end else begin
      req_s_d <= req_s;
      if (push) begin
        served <= 1'b1;
      end
      if (multi_req || idle_fall) begin
        err <= 1'b1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_locker_sync_sink.sv
// ---------------------------------------------------------------------------
// tb_locker_sync_sink
// Directed bench for locker_sync_sink (size=2, width=8, sync_stages=2).
// Stimulus pushes each expected (chan, data) word into a queue; a monitor
// on the falling edge pops and compares whenever a transfer is presented.
// ---------------------------------------------------------------------------
module tb_locker_sync_sink;

  localparam int SIZE  = 2;
  localparam int WIDTH = 8;

  typedef struct {
    logic [0:0]       chan;
    logic [WIDTH-1:0] data;
  } exp_t;

  logic                  clk = 1'b0;
  logic                  rst;
  logic [SIZE-1:0]       req_in;
  logic [SIZE*WIDTH-1:0] data_in;
  logic [SIZE-1:0]       ack_out;
  logic                  valid_out;
  logic                  ready_in;
  logic [WIDTH-1:0]      data_out;
  logic [0:0]            chan_out;
`ifdef LOCKER_SYNC_SINK_ERR_EN
  logic                  err;
`endif

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  locker_sync_sink #(.size(SIZE), .width(WIDTH), .sync_stages(2)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_in    (req_in),
    .data_in   (data_in),
    .ack_out   (ack_out),
`ifdef LOCKER_SYNC_SINK_ERR_EN
    .err       (err),
`endif
    .valid_out (valid_out),
    .ready_in  (ready_in),
    .data_out  (data_out),
    .chan_out  (chan_out)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic expect_word(input logic [0:0] ch, input logic [WIDTH-1:0] d);
    exp_t e;
    e.chan = ch;
    e.data = d;
    exp_q.push_back(e);
  endtask

  // Bounded wait for ack_out[ch] to reach lvl.
  task automatic wait_ack(input int ch, input logic lvl, input string name);
    int n = 0;
    while (ack_out[ch] !== lvl && n < 20) begin
      step(1);
      n++;
    end
    check(name, 32'(ack_out[ch]), 32'(lvl));
  endtask

  // Complete 4-phase handshake on one channel.
  task automatic handshake(input int ch, input logic [WIDTH-1:0] d);
    data_in[ch*WIDTH +: WIDTH] = d;
    req_in[ch] = 1'b1;
    wait_ack(ch, 1'b1, "hs_ack_rise");
    req_in[ch] = 1'b0;
    wait_ack(ch, 1'b0, "hs_ack_fall");
    step(2);
  endtask

  // Bounded wait for the scoreboard to empty.
  task automatic drain(input string name);
    int n = 0;
    while (exp_q.size() != 0 && n < 50) begin
      step(1);
      n++;
    end
    check(name, 32'(exp_q.size()), 32'd0);
  endtask

  // Monitor: samples on the falling edge, away from the active edge.
  always @(negedge clk) begin
    exp_t e;
    if (rst === 1'b1) begin
      check("ack_onehot", 32'($countones(ack_out) <= 1), 32'd1);
      if (valid_out && ready_in) begin
        if (exp_q.size() == 0) begin
          check("unexpected_word", 32'(valid_out), 32'd0);
        end else begin
          e = exp_q.pop_front();
          check("stream_data", 32'(data_out), 32'(e.data));
          check("stream_chan", 32'(chan_out), 32'(e.chan));
        end
      end
    end
  end

  initial begin
    rst      = 1'b0;
    req_in   = '0;
    data_in  = '0;
    ready_in = 1'b0;
    step(2);
    check("rst_ack",   32'(ack_out),   32'd0);
    check("rst_valid", 32'(valid_out), 32'd0);
    check("rst_data",  32'(data_out),  32'd0);
    check("rst_chan",  32'(chan_out),  32'd0);
    rst = 1'b1;
    step(2);

    // ---- Single request: ack 3 edges after req rises and falls -----------
    ready_in = 1'b1;
    expect_word(1'b1, 8'hA5);
    data_in[15:8] = 8'hA5;
    req_in[1]     = 1'b1;
    step(2);
    check("single_ack_early", 32'(ack_out), 32'd0);
    step(1);
    check("single_ack",   32'(ack_out),   32'b10);
    check("single_valid", 32'(valid_out), 32'd1);
    check("single_data",  32'(data_out),  32'hA5);
    check("single_chan",  32'(chan_out),  32'd1);
    req_in[1] = 1'b0;
    step(2);
    check("single_ack_held", 32'(ack_out), 32'b10);
    step(1);
    check("single_ack_drop", 32'(ack_out), 32'd0);
    step(2);
    drain("single_drain");

    // ---- Back-pressure: third request stalls until a pop -----------------
    ready_in = 1'b0;
    expect_word(1'b0, 8'h01);
    expect_word(1'b0, 8'h02);
    expect_word(1'b0, 8'h03);
    handshake(0, 8'h01);
    handshake(0, 8'h02);
    data_in[7:0] = 8'h03;
    req_in[0]    = 1'b1;
    step(10);
    check("bp_no_ack",  32'(ack_out),   32'd0);
    check("bp_valid",   32'(valid_out), 32'd1);
    check("bp_head",    32'(data_out),  32'h01);
    ready_in = 1'b1;
    step(1);  // pop 0x01; FIFO was full so no capture on this edge
    check("bp_no_ack_pop", 32'(ack_out), 32'd0);
    step(1);  // capture 0x03 while popping 0x02: occupancy stays 1
    check("pushpop_ack",   32'(ack_out),   32'b01);
    check("pushpop_valid", 32'(valid_out), 32'd1);
    check("pushpop_head",  32'(data_out),  32'h03);
    req_in[0] = 1'b0;
    wait_ack(0, 1'b0, "bp_ack_fall");
    step(2);
    drain("bp_drain");

    // ---- Alternating channels ---------------------------------------------
    expect_word(1'b0, 8'h11);
    expect_word(1'b1, 8'h22);
    expect_word(1'b0, 8'h33);
    handshake(0, 8'h11);
    handshake(1, 8'h22);
    handshake(0, 8'h33);
    drain("alt_drain");

    // ---- Reset in the middle of a handshake -------------------------------
    ready_in     = 1'b0;
    data_in[7:0] = 8'h44;
    req_in[0]    = 1'b1;
    wait_ack(0, 1'b1, "mid_ack_rise");
    check("mid_valid_before", 32'(valid_out), 32'd1);
    #2;
    rst = 1'b0;
    #1;
    check("mid_rst_ack",   32'(ack_out),   32'd0);
    check("mid_rst_valid", 32'(valid_out), 32'd0);
    @(posedge clk);
    #1;
    rst      = 1'b1;
    ready_in = 1'b1;
    expect_word(1'b0, 8'h44);
    step(2);
    check("mid_reack_early", 32'(ack_out), 32'd0);
    step(1);
    check("mid_reack", 32'(ack_out), 32'b01);
    req_in[0] = 1'b0;
    wait_ack(0, 1'b0, "mid_ack_fall");
    step(2);
    drain("mid_drain");

    // ---- Simultaneous requests: lowest index first ------------------------
    expect_word(1'b0, 8'h10);
    expect_word(1'b1, 8'h20);
    data_in = {8'h20, 8'h10};
    req_in  = 2'b11;
    wait_ack(0, 1'b1, "simul_ack0");
    check("simul_only_ch0", 32'(ack_out), 32'b01);
    req_in[0] = 1'b0;
    wait_ack(1, 1'b1, "simul_ack1");
    check("simul_only_ch1", 32'(ack_out), 32'b10);
    req_in[1] = 1'b0;
    wait_ack(1, 1'b0, "simul_ack1_fall");
    step(2);
    drain("simul_drain");
`ifdef LOCKER_SYNC_SINK_ERR_EN
    check("err_set", 32'(err), 32'd1);
    step(5);
    check("err_sticky", 32'(err), 32'd1);
`endif

    step(2);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
